gravity_ctrl: RTL and testbench



---
 rtl/tetris_pkg.sv | 37 +++
 rtl/gravity_ctrl_tick_counter.sv | 29 ++
 rtl/gravity_ctrl.sv | 167 ++++++++++++++++
 tb/tb_gravity_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared types, default tick constants and the gravity interval helper.
package tetris_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FALL,
    WAIT,
    HARD,
    LAND,
    LOCK
  } grav_state_t;

  localparam int DEF_LEVEL_W    = 4;
  localparam int DEF_MAX_LEVEL  = 10;
  localparam int DEF_BASE_TICKS = 100;
  localparam int DEF_STEP_TICKS = 9;
  localparam int DEF_MIN_TICKS  = 10;
  localparam int DEF_SOFT_TICKS = 5;
  localparam int DEF_LOCK_TICKS = 100;
  localparam int DEF_MAX_RESETS = 15;
  localparam int DEF_CNT_W      = 8;

  // Interval for a level: the level saturates at max_level, then the interval
  // is floored at min_ticks so high levels never reach zero.
  function automatic int gravity_interval(input int level,
                                          input int max_level = DEF_MAX_LEVEL,
                                          input int base      = DEF_BASE_TICKS,
                                          input int step      = DEF_STEP_TICKS,
                                          input int min_ticks = DEF_MIN_TICKS);
    int lvl_sat;
    int iv;
    lvl_sat = (level > max_level) ? max_level : level;
    iv      = base - step * lvl_sat;
    return (iv < min_ticks) ? min_ticks : iv;
  endfunction

endpackage

// File: rtl/gravity_ctrl_tick_counter.sv
// Saturating tick counter; done flags the tick that reaches the limit.
module tick_counter
  import tetris_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] limit,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // The >= compare (not ==) lets a lowered limit fire on the very next tick.
  assign done = tick && (({1'b0, cnt} + 1'b1) >= {1'b0, limit});

  // Count ticks, clear on request, and hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gravity_ctrl.sv
// Gravity, soft/hard drop and lock-delay sequencing for the active piece.
module gravity_ctrl
  import tetris_pkg::*;
#(
  parameter int LEVEL_W    = DEF_LEVEL_W,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int STEP_TICKS = DEF_STEP_TICKS,
  parameter int MIN_TICKS  = DEF_MIN_TICKS,
  parameter int SOFT_TICKS = DEF_SOFT_TICKS,
  parameter int LOCK_TICKS = DEF_LOCK_TICKS,
  parameter int MAX_RESETS = DEF_MAX_RESETS,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               game_clk,
  input  logic               enable,
  input  logic               new_piece,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               hard_drop,
  input  logic               landed,
  input  logic               piece_moved,
  output logic               drop_req,
  input  logic               drop_ack,
  output logic               lock_req,
  input  logic               lock_ack,
  output logic               hard_active
);

  localparam int RST_W = $clog2(MAX_RESETS + 1);

  grav_state_t      state;
  logic [CNT_W-1:0] grav_int_r;
  logic [CNT_W-1:0] grav_next;
  logic [CNT_W-1:0] eff_int;
  logic [RST_W-1:0] resets;
  logic             ack_d;
  logic             grav_done;
  logic             lock_done;
  logic             lock_restart;

  assign grav_next = CNT_W'(gravity_interval(int'(level), MAX_LEVEL, BASE_TICKS,
                                             STEP_TICKS, MIN_TICKS));

  // Soft drop only ever speeds a piece up, never slows a fast level down.
  assign eff_int = (soft_drop && (CNT_W'(SOFT_TICKS) < grav_int_r)) ?
                   CNT_W'(SOFT_TICKS) : grav_int_r;

  // A successful move while resting restarts lock delay, bounded per piece.
  assign lock_restart = (state == LAND) && landed && !hard_drop && piece_moved &&
                        (resets < RST_W'(MAX_RESETS));

  tick_counter #(.CNT_W(CNT_W)) u_grav_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != FALL),
    .tick  (game_clk && (state == FALL)),
    .limit (eff_int),
    .done  (grav_done)
  );

  tick_counter #(.CNT_W(CNT_W)) u_lock_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   ((state != LAND) || lock_restart),
    .tick  (game_clk && (state == LAND)),
    .limit (CNT_W'(LOCK_TICKS)),
    .done  (lock_done)
  );

  // Piece lifecycle FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      drop_req    <= 1'b0;
      lock_req    <= 1'b0;
      hard_active <= 1'b0;
      resets      <= '0;
      ack_d       <= 1'b0;
      grav_int_r  <= '0;
    end else begin
      ack_d <= drop_ack;
      if (!enable) begin
        state       <= IDLE;
        drop_req    <= 1'b0;
        lock_req    <= 1'b0;
        hard_active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            drop_req    <= 1'b0;
            lock_req    <= 1'b0;
            hard_active <= 1'b0;
            if (new_piece) begin
              state      <= FALL;
              resets     <= '0;
              grav_int_r <= grav_next;
            end
          end
          FALL: begin
            if (hard_drop) begin
              state       <= HARD;
              hard_active <= 1'b1;
            end else if (grav_done) begin
              if (landed) begin
                state <= LAND;
              end else begin
                state    <= WAIT;
                drop_req <= 1'b1;
              end
            end
          end
          WAIT: begin
            if (drop_ack) begin
              state      <= FALL;
              drop_req   <= 1'b0;
              grav_int_r <= grav_next;
            end
          end
          HARD: begin
            // One idle cycle after each ack so landed reflects the new row.
            if (drop_req) begin
              if (drop_ack) drop_req <= 1'b0;
            end else if (!ack_d) begin
              if (landed) begin
                state       <= LOCK;
                lock_req    <= 1'b1;
                hard_active <= 1'b0;
              end else begin
                drop_req <= 1'b1;
              end
            end
          end
          LAND: begin
            if (!landed) begin
              state      <= FALL;
              grav_int_r <= grav_next;
            end else if (hard_drop) begin
              state    <= LOCK;
              lock_req <= 1'b1;
            end else if (lock_restart) begin
              resets <= resets + RST_W'(1);
            end else if (lock_done) begin
              state    <= LOCK;
              lock_req <= 1'b1;
            end
          end
          LOCK: begin
            if (lock_ack) begin
              state    <= IDLE;
              lock_req <= 1'b0;
            end
          end
          default: begin
            state       <= IDLE;
            drop_req    <= 1'b0;
            lock_req    <= 1'b0;
            hard_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gravity_ctrl.sv
// Directed bench for gravity_ctrl with hand-computed expectations.
module tb_gravity_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       game_clk = 1'b0;
  logic       enable = 1'b0;
  logic       new_piece = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       hard_drop = 1'b0;
  logic       landed = 1'b0;
  logic       piece_moved = 1'b0;
  logic       drop_req;
  logic       drop_ack = 1'b0;
  logic       lock_req;
  logic       lock_ack = 1'b0;
  logic       hard_active;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  gravity_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .game_clk    (game_clk),
    .enable      (enable),
    .new_piece   (new_piece),
    .level       (level),
    .soft_drop   (soft_drop),
    .hard_drop   (hard_drop),
    .landed      (landed),
    .piece_moved (piece_moved),
    .drop_req    (drop_req),
    .drop_ack    (drop_ack),
    .lock_req    (lock_req),
    .lock_ack    (lock_ack),
    .hard_active (hard_active)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      game_clk = 1'b1;
      cyc();
      game_clk = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ack_drop();
    drop_ack = 1'b1;
    cyc();
    drop_ack = 1'b0;
  endtask

  task automatic ack_lock();
    lock_ack = 1'b1;
    cyc();
    lock_ack = 1'b0;
  endtask

  task automatic spawn();
    new_piece = 1'b1;
    cyc();
    new_piece = 1'b0;
  endtask

  initial begin
    int  pulses;
    bit  prev_req;
    bit  gap_ok;
    bit  hard_ok;

    // Reset
    cyc();
    cyc();
    chk("rst_drop_req", drop_req, 0);
    chk("rst_lock_req", lock_req, 0);
    chk("rst_hard_active", hard_active, 0);
    rst = 1'b0;
    enable = 1'b1;

    // Level 0: 100 ticks per row
    level = 4'd0;
    spawn();
    tick(99);
    chk("lvl0_tick99", drop_req, 0);
    tick(1);
    chk("lvl0_tick100", drop_req, 1);
    tick(3);
    chk("wait_holds_req", drop_req, 1);
    ack_drop();
    chk("ack_drops_req", drop_req, 0);
    tick(99);
    chk("lvl0_restart_99", drop_req, 0);
    tick(1);
    chk("lvl0_restart_100", drop_req, 1);

    // Level 15 saturates to 10: 10 ticks per row
    level = 4'd15;
    ack_drop();
    tick(9);
    chk("lvl15_tick9", drop_req, 0);
    tick(1);
    chk("lvl15_tick10", drop_req, 1);

    // Level 5: 55 ticks per row
    level = 4'd5;
    ack_drop();
    tick(54);
    chk("lvl5_tick54", drop_req, 0);
    tick(1);
    chk("lvl5_tick55", drop_req, 1);

    // Soft drop mid-count fires on the next tick
    ack_drop();
    tick(20);
    chk("soft_pre", drop_req, 0);
    soft_drop = 1'b1;
    tick(1);
    chk("soft_next_tick", drop_req, 1);
    soft_drop = 1'b0;

    // Lock delay with one restart
    level = 4'd15;
    ack_drop();
    landed = 1'b1;
    tick(10);
    chk("land_no_drop", drop_req, 0);
    tick(98);
    piece_moved = 1'b1;
    tick(1);
    piece_moved = 1'b0;
    chk("lock_restart_99", lock_req, 0);
    tick(99);
    chk("lock_after_restart_99", lock_req, 0);
    tick(1);
    chk("lock_after_restart_100", lock_req, 1);
    chk("lock_no_drop_req", drop_req, 0);
    ack_lock();
    chk("lock_ack", lock_req, 0);

    // 16th piece_moved does not restart the lock delay
    landed = 1'b0;
    spawn();
    landed = 1'b1;
    tick(10);
    for (int k = 0; k < 15; k++) begin
      piece_moved = 1'b1;
      cyc();
      piece_moved = 1'b0;
    end
    tick(50);
    piece_moved = 1'b1;
    cyc();
    piece_moved = 1'b0;
    tick(49);
    chk("sixteenth_move_99", lock_req, 0);
    tick(1);
    chk("sixteenth_move_100", lock_req, 1);
    ack_lock();

    // Hard drop: 7 rows then lock without delay
    landed = 1'b0;
    spawn();
    tick(3);
    hard_drop = 1'b1;
    cyc();
    hard_drop = 1'b0;
    pulses   = 0;
    prev_req = 1'b0;
    gap_ok   = 1'b1;
    hard_ok  = 1'b1;
    for (int i = 0; i < 100 && !lock_req; i++) begin
      if (!hard_active) hard_ok = 1'b0;
      if (drop_req) begin
        if (prev_req) gap_ok = 1'b0;
        pulses++;
        drop_ack = 1'b1;
        if (pulses == 7) landed = 1'b1;
      end else begin
        drop_ack = 1'b0;
      end
      prev_req = drop_req;
      cyc();
    end
    drop_ack = 1'b0;
    chk("hard_pulses", pulses, 7);
    chk("hard_gap", gap_ok, 1);
    chk("hard_active_held", hard_ok, 1);
    chk("hard_lock_req", lock_req, 1);
    chk("hard_drop_req_low", drop_req, 0);
    ack_lock();

    // Pause in WAIT
    landed = 1'b0;
    spawn();
    tick(10);
    chk("pause_wait_req", drop_req, 1);
    enable = 1'b0;
    cyc();
    chk("pause_drop_req", drop_req, 0);
    enable = 1'b1;
    ack_drop();
    tick(20);
    chk("pause_idle", drop_req, 0);

    // Reset while in LOCK
    spawn();
    landed = 1'b1;
    tick(10);
    hard_drop = 1'b1;
    cyc();
    hard_drop = 1'b0;
    chk("land_hard_lock", lock_req, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_lock_lock_req", lock_req, 0);
    chk("rst_lock_drop_req", drop_req, 0);
    chk("rst_lock_hard", hard_active, 0);
    landed = 1'b0;
    spawn();
    tick(9);
    chk("post_rst_tick9", drop_req, 0);
    tick(1);
    chk("post_rst_tick10", drop_req, 1);

    // Expiry tick and hard_drop together go to HARD
    ack_drop();
    tick(9);
    game_clk  = 1'b1;
    hard_drop = 1'b1;
    cyc();
    game_clk  = 1'b0;
    hard_drop = 1'b0;
    chk("simul_no_wait", drop_req, 0);
    chk("simul_hard", hard_active, 1);
    landed = 1'b1;
    cyc();
    cyc();
    chk("simul_hard_lock", lock_req, 1);
    ack_lock();

    // landed falls on the final lock tick: back to FALL, no lock
    spawn();
    tick(10);
    tick(99);
    game_clk = 1'b1;
    landed   = 1'b0;
    cyc();
    game_clk = 1'b0;
    chk("unland_no_lock", lock_req, 0);
    tick(9);
    chk("unland_fall_9", drop_req, 0);
    tick(1);
    chk("unland_fall_10", drop_req, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
